// File: rtl/spi_defs_pkg.sv
// Shared definitions for the SPI register-file peripheral:
// FSM state encoding, R/W bit meaning and frame-width helper.
package spi_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int frame_w(
    input int aw,
    input int dw
  );
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchroniser for raw pad inputs.
// Each bit resets to its own idle level from RST_VAL.
module spi_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ff [STAGES];

  // shift the pad levels through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        ff[i] <= RST_VAL;
      end
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_regfile_rw.sv
// SPI mode-0 register file with write and optional read-back.
// Read-back logic is built only with SPI_READBACK_EN defined.
module spi_regfile_rw
  import spi_defs::*;
#(
  parameter int NUM_REGS = 5,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       m_clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       mosi,
  input  logic                       cs_n,
  output logic                       miso,
  output logic                       miso_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam int SR_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam logic [CNT_W-1:0] CNT_CMD = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_W + 1);
  localparam logic [ADDR_W:0] NREG = (ADDR_W + 1)'(NUM_REGS);

  logic [2:0] sync_q;
  logic s_cs, s_sclk, s_mosi;
  logic d_cs, d_sclk;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [SR_W-1:0] sr;
  logic [ADDR_W:0] cmd_nx;
  logic rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic in_range;
  logic clr, shift, bump, capture, commit;

  spi_sync #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (3),
    .RST_VAL(3'b100)
  ) u_sync (
    .clk  (m_clk),
    .rst_n(rst_n),
    .d    ({cs_n, sclk, mosi}),
    .q    (sync_q)
  );

  assign s_cs = sync_q[2];
  assign s_sclk = sync_q[1];
  assign s_mosi = sync_q[0];

  // one-cycle-delayed copies for edge detection
  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      d_cs <= 1'b1;
      d_sclk <= 1'b0;
    end else begin
      d_cs <= s_cs;
      d_sclk <= s_sclk;
    end
  end

  assign cs_fall = d_cs & ~s_cs;
  assign cs_rise = ~d_cs & s_cs;
  assign sclk_rise = ~d_sclk & s_sclk;
  assign sclk_fall = d_sclk & ~s_sclk;

  assign cmd_nx = {sr[ADDR_W-1:0], s_mosi};
  assign in_range = {1'b0, addr_q} < NREG;

  // state register
  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end

  // next state and datapath controls; cs_n edges beat sclk edges
  always_comb begin
    state_nx = state;
    clr = 1'b0;
    shift = 1'b0;
    bump = 1'b0;
    capture = 1'b0;
    commit = 1'b0;
    priority case (1'b1)
      cs_fall: begin
        state_nx = CMD;
        clr = 1'b1;
      end
      cs_rise: begin
        state_nx = IDLE;
        commit = (state == DATA) && (cnt == CNT_FULL) &&
                 (rw_q == RW_WRITE) && in_range;
      end
      sclk_rise: begin
        case (state)
          CMD: begin
            shift = 1'b1;
            bump = 1'b1;
            if (cnt == CNT_CMD) begin
              state_nx = DATA;
              capture = 1'b1;
            end
          end
          DATA: begin
            bump = 1'b1;
            if (cnt == CNT_FULL) state_nx = OVER;
            else shift = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // bit counter, shift-in register, command latch and commit
  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sr <= '0;
      rw_q <= 1'b0;
      addr_q <= '0;
      regs <= '0;
      wr_strobe <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_strobe <= commit;
      if (clr) begin
        cnt <= '0;
        sr <= '0;
      end else begin
        if (bump && cnt != CNT_MAX) cnt <= cnt + 1'b1;
        if (shift) sr <= {sr[SR_W-2:0], s_mosi};
      end
      if (capture) {rw_q, addr_q} <= cmd_nx;
      if (commit) begin
        wr_addr <= addr_q;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (addr_q == ADDR_W'(k))
            regs[k*DATA_W +: DATA_W] <= sr[DATA_W-1:0];
        end
      end
    end
  end

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rd_val;
  logic tx_drive;

  assign tx_drive = sclk_fall && !cs_fall && !cs_rise &&
                    (state == DATA) && (rw_q == RW_READ);

  // addressed register, zero when out of range
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (cmd_nx[ADDR_W-1:0] == ADDR_W'(k))
        rd_val = regs[k*DATA_W +: DATA_W];
    end
  end

  // tx shifter: load at end of command, present a bit per sclk fall
  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr <= '0;
      miso <= 1'b0;
      miso_oe <= 1'b0;
    end else if (clr || cs_rise) begin
      tx_sr <= '0;
      miso <= 1'b0;
      miso_oe <= 1'b0;
    end else if (capture && cmd_nx[ADDR_W] == RW_READ) begin
      tx_sr <= rd_val;
    end else if (tx_drive) begin
      miso <= tx_sr[DATA_W-1];
      miso_oe <= 1'b1;
      tx_sr <= tx_sr << 1;
    end
  end
`else
  assign miso = 1'b0;
  assign miso_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_rw.sv
// Scoreboard bench for spi_regfile_rw with a frame-level model.
// Read-data checks follow SPI_READBACK_EN.
module tb_spi_regfile_rw;

  localparam int NUM_REGS = 5;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam int HP = 6;
`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic m_clk = 1'b0;
  logic rst_n, sclk, mosi, cs_n;
  logic miso, miso_oe, wr_strobe;
  logic [NUM_REGS*DATA_W-1:0] regs;
  logic [ADDR_W-1:0] wr_addr;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [NUM_REGS*DATA_W-1:0] img;
  } exp_t;

  exp_t sbq[$];
  logic [DATA_W-1:0] model [NUM_REGS];
  int n_checks = 0;
  int n_fail = 0;

  always #5 m_clk = ~m_clk;

  spi_regfile_rw #(
    .NUM_REGS(NUM_REGS),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .SYNC_STAGES(2)
  ) dut (
    .m_clk(m_clk),
    .rst_n(rst_n),
    .sclk(sclk),
    .mosi(mosi),
    .cs_n(cs_n),
    .miso(miso),
    .miso_oe(miso_oe),
    .regs(regs),
    .wr_strobe(wr_strobe),
    .wr_addr(wr_addr)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NUM_REGS*DATA_W-1:0] image();
    logic [NUM_REGS*DATA_W-1:0] img;
    for (int k = 0; k < NUM_REGS; k++) img[k*DATA_W +: DATA_W] = model[k];
    return img;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge m_clk);
    #2;
  endtask

  // monitor: every strobe must match the oldest expected commit
  initial begin
    forever begin
      @(negedge m_clk);
      if (rst_n === 1'b1 && wr_strobe === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_strobe", {56'd0, wr_addr}, 64'hFFFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("regs_at_strobe", regs, e.img);
        end
      end
    end
  end

  // send n bits MSB first; cs_last lifts cs_n with the last sclk rise
  task automatic frame(input logic [16:0] bits, input int n,
                       input bit cs_last);
    logic [15:0] f;
    int a;
    bit rd16, commit, exp_oe;
    logic [DATA_W-1:0] got, exp_rd;
    int oe_bad;
    if (n >= 16) f = bits[n-1 -: 16];
    else f = 16'(bits << (16 - n));
    a = int'(f[14:8]);
    rd16 = (n == 16) && !cs_last && (f[15] == 1'b0);
    commit = (n == 16) && !cs_last && f[15] && (a < NUM_REGS);
    exp_rd = (RB && rd16 && a < NUM_REGS) ? model[a] : '0;
    if (commit) begin
      exp_t e;
      model[a] = f[7:0];
      e.addr = ADDR_W'(a);
      e.img = image();
      sbq.push_back(e);
    end
    got = '0;
    oe_bad = 0;
    cs_n = 1'b0;
    wait_cyc(HP);
    for (int i = 0; i < n; i++) begin
      mosi = bits[n-1-i];
      wait_cyc(HP);
      exp_oe = RB && rd16 && (i >= 1 + ADDR_W);
      if (miso_oe !== exp_oe) oe_bad++;
      if (i >= 1 + ADDR_W && i < 1 + ADDR_W + DATA_W)
        got = {got[DATA_W-2:0], miso};
      sclk = 1'b1;
      if (cs_last && i == n - 1) cs_n = 1'b1;
      wait_cyc(HP);
      sclk = 1'b0;
    end
    wait_cyc(HP);
    cs_n = 1'b1;
    wait_cyc(12);
    if (rd16) begin
      chk("read_data", got, exp_rd);
      chk("miso_oe_phase", oe_bad, 0);
    end
    chk("miso_oe_idle", {miso_oe, miso}, 2'b00);
    chk("regs_after_frame", regs, image());
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
    rst_n = 1'b0;
    sclk = 1'b0;
    mosi = 1'b0;
    cs_n = 1'b1;
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(5);
    chk("reset_regs", regs, '0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_strobe_miso", {wr_strobe, miso, miso_oe}, 3'b000);

    frame({1'b0, 16'h82C3}, 16, 1'b0);
    frame({1'b0, 16'h8A55}, 16, 1'b0);
    frame({1'b0, 16'h8101}, 16, 1'b0);
    frame({1'b0, 16'h8100}, 16, 1'b0);
    frame({1'b0, 16'h83A5}, 16, 1'b0);
    frame({1'b0, 16'h0300}, 16, 1'b0);
    frame({1'b0, 16'h0A00}, 16, 1'b0);
    frame(17'h0427F, 15, 1'b0);
    frame({16'h84FF, 1'b1}, 17, 1'b0);
    frame({1'b0, 16'h8455}, 16, 1'b1);
    frame({1'b0, 16'h0200}, 16, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int kind;
      logic [15:0] f;
      kind = int'($urandom_range(0, 9));
      f[15] = (kind <= 5 || kind >= 8);
      f[14:8] = 7'($urandom_range(0, 7));
      f[7:0] = 8'($urandom);
      if (kind <= 7) frame({1'b0, f}, 16, 1'b0);
      else if (kind == 8) frame({2'b0, f[15:1]}, 15, 1'b0);
      else frame({f, 1'b0}, 17, 1'b0);
    end

    // reset in the middle of a write frame
    cs_n = 1'b0;
    wait_cyc(HP);
    for (int i = 0; i < 10; i++) begin
      logic [15:0] v;
      v = 16'h80AA;
      mosi = v[15-i];
      wait_cyc(HP);
      sclk = 1'b1;
      wait_cyc(HP);
      sclk = 1'b0;
    end
    rst_n = 1'b0;
    wait_cyc(3);
    chk("midreset_regs", regs, '0);
    chk("midreset_outs", {wr_strobe, miso, miso_oe, wr_addr}, 0);
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
    cs_n = 1'b1;
    sclk = 1'b0;
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(6);
    frame({1'b0, 16'h8077}, 16, 1'b0);

    for (int w = 0; w < 50 && sbq.size() != 0; w++) wait_cyc(1);
    chk("scoreboard_empty", sbq.size(), 0);
    chk("final_regs", regs, image());
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_regfile_rw.md
Name: spi_regfile_rw

Overview:
- Parametrised SPI mode-0 register-file peripheral: NUM_REGS registers of DATA_W bits, written and now also read over SPI.
- Takes raw pad signals (sclk, mosi, cs_n) and synchronises them internally into m_clk.
- Frame = 1 R/W bit (1 = write), ADDR_W address bits, DATA_W data bits, all MSB first.
- Register contents drive downstream logic (e.g. PWM/IO config); a write strobe flags each committed write.

Parameters:
- NUM_REGS, 5, number of implemented registers (1..2**ADDR_W).
- DATA_W, 8, register and data-field width.
- ADDR_W, 7, address-field width.
- SYNC_STAGES, 2, synchroniser flops per input (>=2).

Ports:
- m_clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sclk  in  1  SPI clock (raw pad).
- mosi  in  1  SPI data in (raw pad).
- cs_n  in  1  SPI chip select, active low (raw pad).
- miso  out  1  SPI data out.
- miso_oe  out  1  high while a read data phase is active; pad tristate control.
- regs  out  NUM_REGS*DATA_W  flattened registers; reg k at [k*DATA_W +: DATA_W].
- wr_strobe  out  1  one-cycle pulse on a committed write.
- wr_addr  out  ADDR_W  address of the last committed write.

Behaviour:
- Reset (async, rst_n low): regs=0, miso=0, miso_oe=0, wr_strobe=0, wr_addr=0, state=IDLE, bit count=0, shift registers=0, synchroniser flops and edge-history flops=idle levels (cs_n=1, sclk=0).
- Sampling: sclk rise/fall and cs_n edges are detected on synchronised signals against a one-cycle-delayed copy. sclk high and low phases must each be >= SYNC_STAGES+2 m_clk cycles.
- FRAME_W = 1+ADDR_W+DATA_W. Bits are sampled on sclk rise.
- FSM states:
  - IDLE: on cs_n fall -> CMD, clear count and shift-in register.
  - CMD: shift in R/W + address. After the (1+ADDR_W)th rise -> DATA. If read and addr<NUM_REGS, load tx shift register with that register; if read and out of range, load 0.
  - DATA: writes shift in data bits. Reads drive miso and set miso_oe=1 on each sclk fall: first fall drives the MSB, later falls shift. A rise beyond FRAME_W -> OVER.
  - OVER: ignore sclk until cs_n rise.
- cs_n rise from any non-IDLE state -> IDLE, miso_oe=0, miso=0. A write commits only if state=DATA, count==FRAME_W, and addr<NUM_REGS.
- Commit: reg[addr]<=data, wr_addr<=addr, wr_strobe=1 for exactly one m_clk cycle. All three occur on the m_clk edge at which the synchronised cs_n rise is detected: SYNC_STAGES+1 m_clk edges after the pad rise is first sampled.
- Short frames, long frames (OVER), out-of-range writes and read frames never modify regs or pulse wr_strobe.
- Simultaneous cs_n edge and sclk edge in the same cycle: the cs_n edge wins and the sclk edge is dropped.
- cs_n fall while not IDLE (glitch): restart in CMD; the partial frame is discarded.
- Reset asserted mid-frame: frame discarded, registers cleared. The first frame after reset release starts at the next cs_n fall.
- Counter width is $clog2(FRAME_W+1); the counter saturates at FRAME_W+1 and never wraps.

Optional Feature:
- SPI_READBACK_EN defined: read frames behave as above.
- Undefined: read frames go CMD->DATA->IDLE with no side effects, the tx logic is not built, and miso/miso_oe are tied to 0.

Decomposition:
- Shared package/include spi_defs: FSM state encoding (IDLE, CMD, DATA, OVER), R/W bit constants (RW_WRITE=1), and a frame-width helper.
- Sub-module spi_sync: SYNC_STAGES-deep, WIDTH-parametrised synchroniser, instantiated once with WIDTH=3 for sclk/mosi/cs_n.

Test Plan:
- Write 0x0A55 (addr 0x0A >= NUM_REGS) after writing 0x02C3 -> reg2=0xC3, one wr_strobe with wr_addr=2; addr 0x0A changes nothing and gives no strobe.
- Frame 0x8101 then 0x8100 -> reg1=0x01, then reg1=0x00 (wr_strobe once each).
- SPI_READBACK_EN: write 0x83A5, then read frame 0x0300 -> miso bits 1,0,1,0,0,1,0,1 on the 8 data rises; miso_oe high only during the data phase; reg3 unchanged.
- 15-bit frame and 17-bit frame with 0x84FF -> reg4 stays 0x00, no wr_strobe.
- Assert rst_n low after 10 bits of 0x80AA, release, send 0x8077 -> reg0=0x77; all regs zero during reset.
- cs_n rise in the same m_clk cycle as the 16th synchronised sclk rise -> frame dropped; reg unchanged.
